mic_hit_detector: RTL and testbench
===================================

Name: mic_hit_detector

Overview:
- Consumer on the audio-input side of Audio_Controller. Pops microphone samples with the audio_in_available/read_audio_in handshake.
- Computes a decaying peak envelope of the left channel and emits a one-cycle hit pulse when the envelope crosses a threshold.
- Hit detection uses hysteresis and a sample-counted hold-off.
- Feeds game logic (strike detection), replacing the passthrough loopback used in the tone demo.

Parameters:
MAG_W, 16, envelope/magnitude width; mag = saturated |sample| bits [30:31-MAG_W]
DECAY_SHIFT, 4, envelope decay per sample: env - (env >> DECAY_SHIFT)
HOLDOFF, 4800, samples after a hit during which no new hit may fire (100 ms at 48 kHz)
CNT_W, 16, hit counter width

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
enable  in  1  1 = consume samples; 0 = stop after current sample
audio_in_available  in  1  Audio_Controller has an input sample
left_channel_audio_in  in  32  signed sample, valid while audio_in_available=1
read_audio_in  out  1  one-cycle pop strobe to Audio_Controller
threshold  in  MAG_W  hit threshold, unsigned, sampled in EVAL
sample_valid  out  1  one-cycle pulse: sample_mag updated
sample_mag  out  MAG_W  magnitude of last popped sample
envelope  out  MAG_W  current envelope
hit  out  1  one-cycle hit pulse
hit_count  out  CNT_W  total hits, saturating
armed  out  1  1 = detector may fire

Behaviour:
- Reset (resetn=0 at an edge): state=WAIT. read_audio_in, sample_valid, hit, sample_mag, envelope, hit_count and holdoff counter all 0. armed=1. Reset overrides everything, including mid-sample.

FSM WAIT -> CAPT -> EVAL -> WAIT:
- WAIT: if enable=1 and audio_in_available=1, drive read_audio_in=1 (combinational, this cycle only). Register left_channel_audio_in on the same edge, go to CAPT. Otherwise read_audio_in=0 and stay in WAIT.
- CAPT: compute abs. 0x8000_0000 saturates to 0x7FFF_FFFF. Register sample_mag = abs[30:31-MAG_W]. Pulse sample_valid=1 on the next cycle (the EVAL cycle). Go to EVAL.
- EVAL: envelope <= (sample_mag > envelope) ? sample_mag : envelope - (envelope >> DECAY_SHIFT). Compute the compare below from the new envelope value (next-state). Go to WAIT.
- read_audio_in is never asserted in CAPT or EVAL, even if audio_in_available=1. Maximum one pop per 3 cycles.
- Hit rule, in EVAL on new env:
  - If armed=1, holdoff=0 and env >= threshold: hit=1 for exactly one cycle (registered, visible the cycle after EVAL), armed<=0, holdoff<=HOLDOFF, hit_count<=hit_count+1, saturating at all-ones.
  - Else if holdoff>0: holdoff<=holdoff-1. Decrement once per processed sample, not per clock.
  - armed<=1 when holdoff=0 and env < (threshold >> 1) (hysteresis re-arm).
- threshold=0: env >= 0 always holds, so a hit fires on every sample where armed=1 and holdoff=0. Re-arm never occurs (nothing is < 0), so exactly one hit after reset. This is specified behaviour.
- enable falling mid-sample: the current sample completes CAPT/EVAL normally; no further pops.
- The right channel is ignored.

Test Plan:
- Reset state: hold resetn=0 for 2 cycles with audio_in_available=1 -> read_audio_in=0, all outputs 0, armed=1.
- Magnitude:
  - sample 0x4000_0000 -> sample_mag=0x8000.
  - sample 0xC000_0000 -> 0x8000.
  - 0x8000_0000 -> 0xFFFF.
  - sample_valid pulses once per popped sample.
- Handshake: audio_in_available held at 1 for 9 cycles -> read_audio_in high on cycles 0, 3 and 6 only. Drop enable at cycle 1 -> exactly one pop.
- Decay: sample 0x4000_0000 then samples of 0 -> envelope 0x8000, 0x7800, 0x7080.
- Hit, hold-off and re-arm (threshold=0x4000, HOLDOFF=4):
  - sample 0x4000_0000 -> hit pulse, hit_count=1, armed=0.
  - Four more loud samples -> no hit.
  - Zeros until envelope < 0x2000 -> armed=1.
  - Next loud sample -> hit_count=2.
- Saturation: CNT_W=2 with 5 separated hits -> hit_count stays at 3.

Source files
------------

// File: rtl/mic_hit_detector.sv
// Microphone strike detector: pops left-channel samples from the audio input FIFO,
// tracks a decaying peak envelope and emits one-cycle hit pulses with hysteresis and hold-off.
module mic_hit_detector #(
  parameter int MAG_W       = 16,
  parameter int DECAY_SHIFT = 4,
  parameter int HOLDOFF     = 4800,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             enable,
  input  logic             audio_in_available,
  input  logic [31:0]      left_channel_audio_in,
  output logic             read_audio_in,
  input  logic [MAG_W-1:0] threshold,
  output logic             sample_valid,
  output logic [MAG_W-1:0] sample_mag,
  output logic [MAG_W-1:0] envelope,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             armed
);

  localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  // Handshake: read_audio_in is a combinational pop strobe, high only in S_WAIT while
  // enable and audio_in_available are both 1; the sample is taken on that same edge.
  typedef enum logic [1:0] {S_WAIT, S_CAPT, S_EVAL} state_t;

  state_t             state_q, state_d;
  logic [31:0]        sample_q, sample_d;
  logic [MAG_W-1:0]   sample_mag_q, sample_mag_d;
  logic               sample_valid_q, sample_valid_d;
  logic [MAG_W-1:0]   env_q, env_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               armed_q, armed_d;
  logic [HOLD_W-1:0]  holdoff_q, holdoff_d;
  logic [31:0]        abs_v;

  // The most negative sample has no positive twin, so it clamps to full scale.
  always_comb begin
    if (sample_q == 32'h8000_0000) abs_v = 32'h7FFF_FFFF;
    else if (sample_q[31])         abs_v = -sample_q;
    else                           abs_v = sample_q;
  end

  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    sample_mag_d   = sample_mag_q;
    sample_valid_d = 1'b0;
    env_d          = env_q;
    hit_d          = 1'b0;
    hit_count_d    = hit_count_q;
    armed_d        = armed_q;
    holdoff_d      = holdoff_q;
    read_audio_in  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (enable && audio_in_available) begin
          read_audio_in = resetn;
          sample_d      = left_channel_audio_in;
          state_d       = S_CAPT;
        end
      end
      S_CAPT: begin
        sample_mag_d   = MAG_W'(abs_v >> (31 - MAG_W));
        sample_valid_d = 1'b1;
        state_d        = S_EVAL;
      end
      S_EVAL: begin
        env_d = (sample_mag_q > env_q) ? sample_mag_q
                                       : env_q - (env_q >> DECAY_SHIFT);
        if (armed_q && (holdoff_q == '0) && (env_d >= threshold)) begin
          hit_d     = 1'b1;
          armed_d   = 1'b0;
          holdoff_d = HOLD_W'(HOLDOFF);
          if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
        end else if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - HOLD_W'(1);
        end
        // Hysteresis: re-arm only once the envelope has fallen below half the threshold.
        if ((holdoff_q == '0) && (env_d < (threshold >> 1))) armed_d = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q        <= S_WAIT;
      sample_q       <= '0;
      sample_mag_q   <= '0;
      sample_valid_q <= 1'b0;
      env_q          <= '0;
      hit_q          <= 1'b0;
      hit_count_q    <= '0;
      armed_q        <= 1'b1;
      holdoff_q      <= '0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample_d;
      sample_mag_q   <= sample_mag_d;
      sample_valid_q <= sample_valid_d;
      env_q          <= env_d;
      hit_q          <= hit_d;
      hit_count_q    <= hit_count_d;
      armed_q        <= armed_d;
      holdoff_q      <= holdoff_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample_mag   = sample_mag_q;
  assign envelope     = env_q;
  assign hit          = hit_q;
  assign hit_count    = hit_count_q;
  assign armed        = armed_q;

endmodule

// File: tb/tb_mic_hit_detector.sv
// Directed bench for mic_hit_detector: vector table for magnitude/decay plus
// hand-written sequences for handshake, hold-off, re-arm and counter saturation.
module tb_mic_hit_detector;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        avail;
  logic [31:0] left;
  logic        read_audio_in;
  logic [15:0] threshold;
  logic        sample_valid;
  logic [15:0] sample_mag;
  logic [15:0] envelope;
  logic        hit;
  logic [1:0]  hit_count;
  logic        armed;

  int n_pass  = 0;
  int n_total = 0;
  int pops    = 0;
  int svs     = 0;

  always #5 clk = ~clk;

  mic_hit_detector #(
    .MAG_W(16), .DECAY_SHIFT(4), .HOLDOFF(4), .CNT_W(2)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .enable(enable),
    .audio_in_available(avail),
    .left_channel_audio_in(left),
    .read_audio_in(read_audio_in),
    .threshold(threshold),
    .sample_valid(sample_valid),
    .sample_mag(sample_mag),
    .envelope(envelope),
    .hit(hit),
    .hit_count(hit_count),
    .armed(armed)
  );

  always @(posedge clk) begin
    if (read_audio_in) pops++;
    if (sample_valid)  svs++;
  end

  typedef struct {
    logic [31:0] sample;
    logic [15:0] mag;
    logic [15:0] env;
    logic        hit;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b1;
    avail  = 1'b1;
    left   = 32'h4000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", read_audio_in, 1'b0);
    check("rst_outs", {sample_valid, sample_mag, envelope, hit, hit_count}, '0);
    check("rst_armed", armed, 1'b1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    avail  = 1'b0;
    left   = '0;
  endtask

  // One full pop/capture/evaluate round; results are sampled the cycle after EVAL.
  task automatic do_sample(input logic [31:0] s, output logic [15:0] mag,
                           output logic [15:0] env, output logic h,
                           output logic [1:0] cnt, output logic arm);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    avail  = 1'b1;
    left   = s;
    @(negedge clk);
    while (!read_audio_in && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!read_audio_in) begin
      n_total++;
      $display("FAIL pop_timeout: got read_audio_in=0 expected 1 within 10 cycles");
    end
    @(posedge clk);
    #1;
    avail = 1'b0;
    left  = '0;
    @(negedge clk);
    @(negedge clk);
    check("sample_valid_eval", sample_valid, 1'b1);
    mag = sample_mag;
    @(negedge clk);
    env = envelope;
    h   = hit;
    cnt = hit_count;
    arm = armed;
  endtask

  // Feeds zeros until the detector re-arms; expected envelope tracked arithmetically.
  task automatic rearm(input logic [15:0] env_start);
    logic [15:0] m, e, em;
    logic        h, a;
    logic [1:0]  c;
    int          k;
    em = env_start;
    k  = 0;
    a  = 1'b0;
    while (!a && k < 60) begin
      do_sample(32'h0, m, e, h, c, a);
      em = em - (em >> 4);
      check("decay_env", e, em);
      k++;
    end
    check("rearm_armed", a, 1'b1);
    check("rearm_below_half", em < 16'h2000, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m, e;
    logic        h, a;
    logic [1:0]  c;
    logic [8:0]  got;
    int          n, hits;

    vecs[0] = '{32'h4000_0000, 16'h8000, 16'h8000, 1'b0};
    vecs[1] = '{32'h0000_0000, 16'h0000, 16'h7800, 1'b0};
    vecs[2] = '{32'h0000_0000, 16'h0000, 16'h7080, 1'b0};
    vecs[3] = '{32'hC000_0000, 16'h8000, 16'h8000, 1'b0};
    vecs[4] = '{32'h8000_0000, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[5] = '{32'h0001_0000, 16'h0002, 16'hF000, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 16'h0000, 16'hE100, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b0};

    threshold = 16'hFFFF;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_sample(vecs[i].sample, m, e, h, c, a);
      check($sformatf("vec%0d_mag", i), m, vecs[i].mag);
      check($sformatf("vec%0d_env", i), e, vecs[i].env);
      check($sformatf("vec%0d_hit", i), h, vecs[i].hit);
    end

    // Continuous availability: pops only every third cycle.
    @(posedge clk);
    #1;
    avail = 1'b1;
    left  = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      got[i] = read_audio_in;
    end
    avail = 1'b0;
    check("pop_pattern", got, 9'b001_001_001);
    repeat (3) @(posedge clk);

    // enable drops one cycle after the pop: that sample completes, no more pops.
    @(posedge clk);
    #1;
    avail = 1'b1;
    n = 0;
    @(negedge clk);
    if (read_audio_in) n++;
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (read_audio_in) n++;
    end
    check("enable_drop_pops", n, 1);
    avail  = 1'b0;
    enable = 1'b1;
    check("sv_per_pop", svs, pops);

    // Hit, hold-off and hysteresis re-arm.
    threshold = 16'h4000;
    do_reset();
    do_sample(32'h4000_0000, m, e, h, c, a);
    check("hit1_pulse", h, 1'b1);
    check("hit1_count", c, 2'd1);
    check("hit1_armed", a, 1'b0);
    @(negedge clk);
    check("hit1_one_cycle", hit, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_sample(32'h4000_0000, m, e, h, c, a);
      check($sformatf("holdoff%0d_nohit", i), h, 1'b0);
    end
    check("holdoff_env", e, 16'h8000);
    rearm(16'h8000);
    do_sample(32'h4000_0000, m, e, h, c, a);
    check("hit2_pulse", h, 1'b1);
    check("hit2_count", c, 2'd2);

    // Saturation of the 2-bit counter across five separated hits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_sample(32'h4000_0000, m, e, h, c, a);
      check($sformatf("sat_hit%0d", i), h, 1'b1);
      check($sformatf("sat_count%0d", i), c, (i < 3) ? 2'(i + 1) : 2'd3);
      rearm(e);
    end

    // Zero threshold: exactly one hit after reset, never re-arms.
    threshold = 16'h0000;
    do_reset();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      do_sample(32'h0, m, e, h, c, a);
      if (h) hits++;
    end
    check("thr0_hits", hits, 1);
    check("thr0_count", c, 2'd1);
    check("thr0_armed", a, 1'b0);
    check("sv_per_pop_final", svs, pops);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
